fb_fetch_scheduler: RTL and testbench
=====================================

# fb_fetch_scheduler

Frame-buffer access scheduler between the VGA refresh path and the drawing engine. Owns the single-port frame-buffer memory. Prefetches display pixels into a small FIFO that drives the refresh engine's `current_pixel`. Grants every memory cycle the display path does not need to drawing-engine writes.

## Interface

Parameters:
- `DATA_W`, 12, pixel width (4:4:4 RGB).
- `ADDR_W`, 19, frame-buffer word address width.
- `FRAME_WORDS`, 307200, pixels per frame (640x480).
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of two).

Ports:
- `clk`  in  1  pixel clock; one memory access per cycle max.
- `rst_`  in  1  reset, asynchronous, active-low.
- `en_fetching`  in  1  from refresh engine; low for one line per frame (frame restart).
- `active_video`  in  1  from refresh engine; each high cycle consumes one pixel.
- `current_pixel`  out  DATA_W  FIFO head to refresh engine.
- `draw_req`  in  1  drawing engine write request.
- `draw_addr`  in  ADDR_W  write address.
- `draw_data`  in  DATA_W  write data.
- `draw_gnt`  out  1  write performed this cycle.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_rd_en`  out  1  read strobe.
- `mem_wr_en`  out  1  write strobe.
- `mem_wdata`  out  DATA_W  write data.
- `mem_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd_en`.
- `underflow`  out  1  sticky; set when a pixel was consumed from an empty FIFO.

## Operation

- FIFO: `FIFO_DEPTH` x `DATA_W`, registered storage.
  - `count` uses clog2(DEPTH)+1 bits.
  - `current_pixel` is the combinational head when `count`>0, else 0.
- Read pointer `rd_addr` (ADDR_W) is the next frame word to fetch. `pending` (1 bit) marks a read issued last cycle.
- States:
  - IDLE: `en_fetching`=0. FIFO flushed each cycle, `rd_addr`=0, no reads issued. Draw writes are granted every cycle requested.
  - FETCH: entered when `en_fetching`=1. Goes to DONE when a read is issued with `rd_addr`=FRAME_WORDS-1.
  - DONE: no reads issued; draw gets every cycle.
  - Any state goes to IDLE when `en_fetching`=0. This aborts the frame: the FIFO is flushed and in-flight read data is discarded.
- Arbitration, per cycle:
  - A display read is issued in FETCH when `count + pending - pop < FIFO_DEPTH`. Display has absolute priority.
  - Otherwise, if `draw_req`, a write is issued: `mem_wr_en`=1, `mem_addr`=`draw_addr`, `draw_gnt`=1 in the same cycle.
  - `mem_rd_en` and `mem_wr_en` are never both 1.
  - `mem_addr` = `rd_addr` on reads, `draw_addr` on writes, 0 when idle.
- Push: when `pending`=1 and the state is not IDLE, `mem_rdata` is written at the FIFO tail.
- Pop: `active_video`=1 and `count`>0.
- Underflow: `active_video`=1 and `count`=0. Sets the `underflow` flag, which clears only on reset. No pop occurs.
- Push and pop in the same cycle: `count` unchanged; the entry pushed to an empty FIFO is not bypassed.
- `rd_addr` increments by 1 per issued read and never exceeds FRAME_WORDS-1. There is no wrap within a frame.

## Timing

- Reset values: `current_pixel`=0, `draw_gnt`=0, `mem_rd_en`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, `underflow`=0. Internal state: IDLE, `count`=0, `pending`=0, `rd_addr`=0.
- Memory outputs and `draw_gnt` are combinational from registered state plus `draw_req` / `active_video`.
- Latency:
  - Read issued in cycle t: data arrives on `mem_rdata` in t+1 and is visible at `current_pixel` in t+2.
  - First read is in the first cycle with `en_fetching`=1.
  - FIFO is full `FIFO_DEPTH`+1 cycles later.
- Steady state during active video: one read per popped pixel; `draw_gnt` stays low.
- Drawing bandwidth comes from blanking, IDLE and DONE cycles.
- Reset mid-frame: all state returns to reset values immediately; no memory strobe is asserted while `rst_`=0.

## Test plan

- Prefill: assert `en_fetching`, `active_video`=0, memory returns data=address.
  - Reads at addresses 0..15 in consecutive cycles; `count`=16.
  - `mem_rd_en` then low; `current_pixel`=0x000 (address 0).
- Streaming: prefill, then hold `active_video` for 640 cycles.
  - `current_pixel` follows 0,1,2,...,639 (mod 4096) with no gaps.
  - `underflow`=0; `draw_gnt`=0 throughout.
- Draw sharing: FIFO full, `draw_req`=1, `draw_addr`=0x12345, `draw_data`=0xABC.
  - `mem_wr_en`=1 with that address and data, `draw_gnt`=1 each cycle.
  - When one pixel is popped, the next cycle is a read and `draw_gnt`=0.
- Underflow: from IDLE, raise `en_fetching` and `active_video` together.
  - Cycles 0–1: `current_pixel`=0 and `underflow` becomes 1, staying 1 until reset.
  - Pixel 0 appears in cycle 2.
- Frame end/abort:
  - Drive the frame to completion: the last read is at 307199, then DONE with no reads.
  - Drop `en_fetching` with a read pending: the FIFO flushes, stale data is not pushed, and the next frame restarts at address 0.
- Async reset asserted during a write: `mem_wr_en` and `draw_gnt` drop immediately, and all outputs take their reset values.

Source files
------------

// File: rtl/fb_fetch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fb_fetch_scheduler
// Purpose  : Frame-buffer arbiter. Display prefetch has priority; draw writes
//            use every spare cycle.
// Revision : 1.0 - initial release
// ============================================================================
module fb_fetch_scheduler #(
    parameter int DATA_W      = 12,
    parameter int ADDR_W      = 19,
    parameter int FRAME_WORDS = 307200,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              en_fetching,
    input  logic              active_video,
    output logic [DATA_W-1:0] current_pixel,
    input  logic              draw_req,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_data,
    output logic              draw_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              underflow
);

    localparam int                c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int                c_CNT_W     = c_PTR_W + 1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    localparam logic [c_CNT_W:0]  c_DEPTH     = (c_CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_pending;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_underflow;

    logic                w_empty;
    logic                w_pop;
    logic                w_push;
    logic                w_rd;
    logic                w_wr;
    logic [c_CNT_W:0]    w_level;

    // The first read must go out in the first en_fetching cycle, so the
    // fetch decision looks at en_fetching directly rather than waiting for
    // the state register to leave IDLE.
    assign w_empty = (r_count == '0);
    assign w_pop   = active_video && !w_empty;
    assign w_push  = r_pending && en_fetching;
    assign w_level = {1'b0, r_count} + (c_CNT_W + 1)'(r_pending) - (c_CNT_W + 1)'(w_pop);
    assign w_rd    = rst_ && en_fetching && (r_state != ST_DONE) && (w_level < c_DEPTH);
    assign w_wr    = rst_ && draw_req && !w_rd;

    always_comb begin
        w_state_nxt   = r_state;
        mem_rd_en     = w_rd;
        mem_wr_en     = w_wr;
        draw_gnt      = w_wr;
        mem_addr      = '0;
        mem_wdata     = '0;
        current_pixel = '0;
        if (!en_fetching) begin
            w_state_nxt = ST_IDLE;
        end else if (r_state != ST_DONE) begin
            w_state_nxt = (w_rd && (r_rd_addr == c_LAST_ADDR)) ? ST_DONE : ST_FETCH;
        end
        if (w_rd) begin
            mem_addr = r_rd_addr;
        end else if (w_wr) begin
            mem_addr  = draw_addr;
            mem_wdata = draw_data;
        end
        if (!w_empty) begin
            current_pixel = r_fifo[r_rd_ptr];
        end
    end

    assign underflow = r_underflow;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state     <= ST_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_pending   <= 1'b0;
            r_rd_addr   <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (!en_fetching) begin
                // Frame abort: any read still in flight is dropped here.
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_pending <= 1'b0;
                r_rd_addr <= '0;
            end else begin
                r_pending <= w_rd;
                if (w_rd && (r_rd_addr != c_LAST_ADDR)) begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_W'(1);
                end
            end
            if (active_video && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fb_fetch_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fb_fetch_scheduler
// Purpose  : Directed bench with a queue-based reference model of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fb_fetch_scheduler;

    localparam int DW = 12;
    localparam int AW = 19;
    localparam int FW = 1000;
    localparam int D  = 16;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          en_fetching = 1'b0;
    logic          active_video = 1'b0;
    logic [DW-1:0] current_pixel;
    logic          draw_req = 1'b0;
    logic [AW-1:0] draw_addr = '0;
    logic [DW-1:0] draw_data = '0;
    logic          draw_gnt;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          underflow;

    int vectors     = 0;
    int miscompares = 0;

    fb_fetch_scheduler #(
        .DATA_W(DW), .ADDR_W(AW), .FRAME_WORDS(FW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_(rst_), .en_fetching(en_fetching), .active_video(active_video),
        .current_pixel(current_pixel), .draw_req(draw_req), .draw_addr(draw_addr),
        .draw_data(draw_data), .draw_gnt(draw_gnt), .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Memory returns its own address; 0xEEE marks cycles with no read behind them.
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem_addr[DW-1:0] : 12'hEEE;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pixel queue, one in-flight read, frame read pointer.
    int q[$];
    bit m_pend, m_done, m_uf;
    int m_pend_addr, m_rd_addr;
    int e_cur, e_lvl, e_addr, e_wdata;
    bit e_pop, e_rd, e_wr, e_ufset;

    always @(negedge clk) begin
        if (!rst_) begin
            q.delete();
            m_pend = 0; m_done = 0; m_uf = 0; m_rd_addr = 0; m_pend_addr = 0;
        end else begin
            e_cur   = (q.size() > 0) ? q[0] : 0;
            e_pop   = active_video && (q.size() > 0);
            e_ufset = active_video && (q.size() == 0);
            e_lvl   = q.size() + int'(m_pend) - int'(e_pop);
            e_rd    = en_fetching && !m_done && (e_lvl < D);
            e_wr    = !e_rd && draw_req;
            e_addr  = e_rd ? m_rd_addr : (e_wr ? int'(draw_addr) : 0);
            e_wdata = e_wr ? int'(draw_data) : 0;
            chk("model_pixel",    32'(current_pixel), 32'(e_cur));
            chk("model_rd_en",    32'(mem_rd_en),     32'(e_rd));
            chk("model_wr_en",    32'(mem_wr_en),     32'(e_wr));
            chk("model_gnt",      32'(draw_gnt),      32'(e_wr));
            chk("model_addr",     32'(mem_addr),      32'(e_addr));
            chk("model_wdata",    32'(mem_wdata),     32'(e_wdata));
            chk("model_underflow",32'(underflow),     32'(m_uf));
            if (e_ufset) m_uf = 1;
            if (!en_fetching) begin
                q.delete();
                m_pend = 0; m_done = 0; m_rd_addr = 0;
            end else begin
                if (e_pop) void'(q.pop_front());
                if (m_pend) q.push_back(m_pend_addr % 4096);
                m_pend = e_rd;
                if (e_rd) begin
                    m_pend_addr = m_rd_addr;
                    if (m_rd_addr == FW - 1) m_done = 1;
                    else m_rd_addr++;
                end
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic prefill();
        for (int k = 0; k < 20; k++) begin
            half();
            if (k < 16) begin
                chk("prefill_rd_en", 32'(mem_rd_en), 32'd1);
                chk("prefill_addr",  32'(mem_addr),  32'(k));
            end else begin
                chk("prefill_rd_idle", 32'(mem_rd_en), 32'd0);
            end
            nxt();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        int max_addr;

        // Reset with a live draw request: no strobe may escape.
        draw_req = 1'b1; draw_addr = 19'h00055; draw_data = 12'h123;
        repeat (2) nxt();
        half();
        chk("rst_pixel",  32'(current_pixel), 32'd0);
        chk("rst_wr_en",  32'(mem_wr_en),     32'd0);
        chk("rst_rd_en",  32'(mem_rd_en),     32'd0);
        chk("rst_gnt",    32'(draw_gnt),      32'd0);
        chk("rst_addr",   32'(mem_addr),      32'd0);
        chk("rst_wdata",  32'(mem_wdata),     32'd0);
        chk("rst_uflow",  32'(underflow),     32'd0);
        nxt();
        rst_ = 1'b1;

        half();
        chk("idle_gnt",  32'(draw_gnt), 32'd1);
        chk("idle_addr", 32'(mem_addr), 32'h00055);
        nxt();

        draw_req = 1'b0; en_fetching = 1'b1;
        prefill();
        half();
        chk("prefill_head", 32'(current_pixel), 32'h000);
        nxt();

        // FIFO full: draw owns the memory.
        draw_req = 1'b1; draw_addr = 19'h12345; draw_data = 12'hABC;
        for (int k = 0; k < 3; k++) begin
            half();
            chk("share_wr_en", 32'(mem_wr_en), 32'd1);
            chk("share_addr",  32'(mem_addr),  32'h12345);
            chk("share_wdata", 32'(mem_wdata), 32'hABC);
            chk("share_gnt",   32'(draw_gnt),  32'd1);
            nxt();
        end
        active_video = 1'b1;
        half();
        chk("pop_rd_en", 32'(mem_rd_en), 32'd1);
        chk("pop_addr",  32'(mem_addr),  32'd16);
        chk("pop_gnt",   32'(draw_gnt),  32'd0);
        nxt();

        // Abort while the read of address 16 is in flight.
        active_video = 1'b0; en_fetching = 1'b0;
        half();
        chk("abort_rd_en", 32'(mem_rd_en),     32'd0);
        chk("abort_head",  32'(current_pixel), 32'd1);
        nxt();
        half();
        chk("abort_flushed", 32'(current_pixel), 32'd0);
        nxt();

        draw_req = 1'b0; en_fetching = 1'b1;
        prefill();

        draw_req = 1'b1; active_video = 1'b1;
        for (int i = 0; i < 640; i++) begin
            half();
            chk("stream_pixel", 32'(current_pixel), 32'(i % 4096));
            chk("stream_gnt",   32'(draw_gnt),      32'd0);
            chk("stream_uflow", 32'(underflow),     32'd0);
            nxt();
        end

        found = 0; max_addr = 0;
        for (int n = 0; n < 2000 && !found; n++) begin
            half();
            if (mem_rd_en) begin
                if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
                if (int'(mem_addr) == FW - 1) found = 1;
            end
            nxt();
        end
        active_video = 1'b0;
        chk("last_read_seen", 32'(found),    32'd1);
        chk("max_read_addr",  32'(max_addr), 32'd999);

        for (int k = 0; k < 20; k++) begin
            half();
            chk("done_no_read", 32'(mem_rd_en), 32'd0);
            chk("done_gnt",     32'(draw_gnt),  32'd1);
            nxt();
        end

        // Underflow from a cold start.
        draw_req = 1'b0; en_fetching = 1'b0;
        repeat (2) nxt();
        en_fetching = 1'b1; active_video = 1'b1;
        half();
        chk("uf_c0_pixel", 32'(current_pixel), 32'd0);
        chk("uf_c0_flag",  32'(underflow),     32'd0);
        chk("uf_c0_addr",  32'(mem_addr),      32'd0);
        nxt();
        half();
        chk("uf_c1_flag",  32'(underflow),     32'd1);
        chk("uf_c1_pixel", 32'(current_pixel), 32'd0);
        nxt();
        half();
        chk("uf_c2_pixel", 32'(current_pixel), 32'd0);
        nxt();
        half();
        chk("uf_c3_pixel", 32'(current_pixel), 32'd1);
        nxt();
        active_video = 1'b0; en_fetching = 1'b0;
        repeat (3) nxt();
        half();
        chk("uf_sticky", 32'(underflow), 32'd1);
        nxt();

        // Asynchronous reset in the middle of a write cycle.
        draw_req = 1'b1; draw_addr = 19'h7ABCD; draw_data = 12'h5A5;
        half();
        chk("arst_pre_wr", 32'(mem_wr_en), 32'd1);
        #2 rst_ = 1'b0;
        #1;
        chk("arst_wr_en", 32'(mem_wr_en),     32'd0);
        chk("arst_gnt",   32'(draw_gnt),      32'd0);
        chk("arst_addr",  32'(mem_addr),      32'd0);
        chk("arst_wdata", 32'(mem_wdata),     32'd0);
        chk("arst_uflow", 32'(underflow),     32'd0);
        chk("arst_pixel", 32'(current_pixel), 32'd0);
        chk("arst_rd_en", 32'(mem_rd_en),     32'd0);
        repeat (2) nxt();
        draw_req = 1'b0;
        rst_ = 1'b1;
        repeat (3) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
